mv_gen_ctrl: RTL and testbench
==============================

Name: mv_gen_ctrl

Overview:
- FSM that sequences the affine motion-vector generator datapath over one 16x16 block, split into a 4x4 raster grid of 4x4 subblocks.
- Per job: latches coords and CPMVs, initialises X/Y, steps through 16 subblocks and hands each generated MV to the interpolation fetch stage with a valid/ready handshake.
- Uses the datapath's CTRL_X/CTRL_Y flags to decide next-column / next-line / done, and pulses the datapath clear between jobs.

Parameters:
- CALC_LAT, 1, cycles spent in CALC per subblock (>=1); the MV generator output is sampled in the last CALC cycle.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- START  in  1  job request; accepted when START & READY & !ABORT
- ABORT  in  1  synchronous job cancel
- READY  out  1  controller idle, can accept START
- BUSY  out  1  job in progress (INIT..DONE)
- DONE  out  1  one-cycle pulse, all 16 subblocks emitted
- CTRL_X  in  1  datapath flag, 0 = current subblock is in the last row
- CTRL_Y  in  1  datapath flag, 0 = current subblock is in the last column
- INTERP_X  in  1  datapath: horizontal fractional MV (combinational, current X/Y)
- INTERP_Y  in  1  datapath: vertical fractional MV
- RST_ASYNC_MV_GEN  out  1  datapath register clear, active-low
- WRITE_REGS_COORDS  out  1  datapath enable
- WRITE_REGS_CPMVS  out  1  datapath enable
- WRITE_REGS_GEN_MVS  out  1  datapath enable
- WRITE_REG_X  out  1  datapath enable
- WRITE_REG_Y  out  1  datapath enable
- WRITE_REG_COUNT_BLOCK  out  1  datapath enable
- SEL_X  out  1  0 = reload original X coord, 1 = X+1
- SEL_Y  out  1  0 = reload original Y coord, 1 = Y+1
- OUT_VALID  out  1  generated MV registers hold a subblock MV
- OUT_READY  in  1  consumer accepts the MV
- OUT_INTERP_X  out  1  registered INTERP_X for the emitted subblock
- OUT_INTERP_Y  out  1  registered INTERP_Y for the emitted subblock
- OUT_BLK_IDX  out  4  raster index of the emitted subblock (row*4+col)
- NUM_INTERP  out  5  count of subblocks in the job with INTERP_X|INTERP_Y

Behaviour:
- Single clock domain. Reset is synchronous and active-high; all state is registered on CLK.
- States: CLEAR, IDLE, INIT, CALC, EMIT, DONE.
- RST: at the next edge, state=CLEAR, calc counter=0, OUT_INTERP_X/Y=0, OUT_BLK_IDX=0, NUM_INTERP=0.
  - While RST=1, RST_ASYNC_MV_GEN is forced 0 combinationally; READY, BUSY, DONE, OUT_VALID and all enables are 0.
- CLEAR (1 cycle): RST_ASYNC_MV_GEN=0 -> IDLE.
- IDLE: READY=1.
  - On accept (START & !ABORT): WRITE_REGS_COORDS=WRITE_REGS_CPMVS=1 in the same cycle (Mealy). Upstream holds COORD/CPMV only in the accept cycle.
  - Accept also clears NUM_INTERP and OUT_BLK_IDX -> INIT.
- INIT (1 cycle): WRITE_REG_X=WRITE_REG_Y=1, SEL_X=SEL_Y=0 -> CALC.
- CALC (CALC_LAT cycles): in the last cycle, WRITE_REGS_GEN_MVS=1, OUT_INTERP_X/Y<=INTERP_X/Y, and NUM_INTERP += (INTERP_X|INTERP_Y) -> EMIT.
- EMIT: OUT_VALID=1; hold until OUT_READY. On handshake (Mealy, same cycle):
  - WRITE_REG_COUNT_BLOCK=1 and OUT_BLK_IDX+=1.
  - Decode {CTRL_X,CTRL_Y} using the pre-increment count.
  - 11 or 01: next column. WRITE_REG_X=1, SEL_X=1 -> CALC.
  - 10: next line. WRITE_REG_X=1, SEL_X=0, WRITE_REG_Y=1, SEL_Y=1 -> CALC.
  - 00: last subblock -> DONE. The count wraps 15->0.
- DONE (1 cycle): DONE=1, RST_ASYNC_MV_GEN=0 (clears the datapath for the next job) -> IDLE.
- BUSY=1 in INIT, CALC, EMIT and DONE.
- OUT_INTERP_X/Y and OUT_BLK_IDX are stable while OUT_VALID=1. NUM_INTERP holds from DONE until the next accept.
- Latency with OUT_READY=1 and CALC_LAT=1: accept at cycle 0, INIT at 1, subblock k in CALC at 2+2k and EMIT at 3+2k, DONE at 34, READY at 35.
- OUT_READY low: the EMIT state stalls indefinitely and no enables are asserted.
- ABORT in INIT/CALC/EMIT/DONE: OUT_VALID and all enables are forced 0 that cycle (no handshake, no DONE) -> CLEAR. NUM_INTERP holds its partial value.
- ABORT in IDLE: START is not accepted; state stays IDLE.
- ABORT in CLEAR: no effect.
- START while not IDLE: ignored.
- RST mid-job: the job is abandoned immediately and no DONE is issued.
- Unused datapath enables are 0 in every state not listed above.

Test Plan:
- Reset then IDLE: RST 3 cycles -> RST_ASYNC_MV_GEN=0 during RST and one cycle after; READY=1 one cycle after the CLEAR cycle; all enables 0 throughout.
- Full job, OUT_READY tied 1, CALC_LAT=1: START pulse at cycle 0 -> 16 OUT_VALID pulses at cycles 3,5,...,33 with OUT_BLK_IDX 0..15; SEL_Y=1 handshakes at idx 3, 7, 11; DONE at cycle 34; READY at 35.
- Backpressure: OUT_READY=0 for 5 cycles at subblock 6 -> OUT_VALID held 5 extra cycles, OUT_BLK_IDX=6 stable, no WRITE_* asserted; DONE at cycle 39.
- INTERP counting: drive INTERP_X=1 on subblocks 0 and 5, INTERP_Y=1 on subblock 5, 0 otherwise -> NUM_INTERP=2 at DONE; OUT_INTERP_X/Y match the driven values per emitted subblock.
- ABORT during EMIT of subblock 9 with OUT_READY=1 -> no handshake that cycle, CLEAR next cycle with RST_ASYNC_MV_GEN=0, no DONE, READY two cycles after ABORT. A subsequent START yields a full 16-subblock job.
- CALC_LAT=3: one WRITE_REGS_GEN_MVS per subblock, asserted in the 3rd CALC cycle; DONE at cycle 66 after accept. START asserted in cycles 10-20 is ignored with no effect.

Source files
------------

// File: rtl/mv_gen_ctrl.sv
// mv_gen_ctrl: sequencing FSM for the affine motion-vector generator datapath.
// Walks one 16x16 block as a 4x4 raster of 4x4 subblocks and hands each
// generated MV to the interpolation fetch stage over a valid/ready handshake.
//
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   START, ABORT, READY, BUSY,   job control / status
//   DONE
//   CTRL_X, CTRL_Y               datapath flags (0 = last row / last column)
//   INTERP_X, INTERP_Y           datapath fractional-MV flags for current X/Y
//   RST_ASYNC_MV_GEN             datapath register clear, active-low
//   WRITE_*                      datapath register enables
//   SEL_X, SEL_Y                 0 = reload original coord, 1 = increment
//   OUT_VALID, OUT_READY         MV handshake to the fetch stage
//   OUT_INTERP_X/Y, OUT_BLK_IDX  sideband for the emitted subblock
//   NUM_INTERP                   subblocks in the job needing interpolation
module mv_gen_ctrl #(
    parameter int unsigned CALC_LAT = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       ABORT,
    output logic       READY,
    output logic       BUSY,
    output logic       DONE,
    input  logic       CTRL_X,
    input  logic       CTRL_Y,
    input  logic       INTERP_X,
    input  logic       INTERP_Y,
    output logic       RST_ASYNC_MV_GEN,
    output logic       WRITE_REGS_COORDS,
    output logic       WRITE_REGS_CPMVS,
    output logic       WRITE_REGS_GEN_MVS,
    output logic       WRITE_REG_X,
    output logic       WRITE_REG_Y,
    output logic       WRITE_REG_COUNT_BLOCK,
    output logic       SEL_X,
    output logic       SEL_Y,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic       OUT_INTERP_X,
    output logic       OUT_INTERP_Y,
    output logic [3:0] OUT_BLK_IDX,
    output logic [4:0] NUM_INTERP
);

    localparam int unsigned CNT_W   = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned NUM_W   = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CALC_LAT - 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_INIT,
        S_CALC,
        S_EMIT,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   calc_cnt_q, calc_cnt_d;
    logic               out_ix_q, out_ix_d;
    logic               out_iy_q, out_iy_d;
    logic [IDX_W-1:0]   blk_idx_q, blk_idx_d;
    logic [NUM_W-1:0]   num_interp_q, num_interp_d;

    logic ready_c, busy_c, done_c, rst_mv_n_c, valid_c;
    logic wr_coords_c, wr_cpmvs_c, wr_gen_c, wr_x_c, wr_y_c, wr_cnt_c;
    logic sel_x_c, sel_y_c;

    // State and sideband registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_CLEAR;
            calc_cnt_q   <= '0;
            out_ix_q     <= 1'b0;
            out_iy_q     <= 1'b0;
            blk_idx_q    <= '0;
            num_interp_q <= '0;
        end else begin
            state_q      <= state_d;
            calc_cnt_q   <= calc_cnt_d;
            out_ix_q     <= out_ix_d;
            out_iy_q     <= out_iy_d;
            blk_idx_q    <= blk_idx_d;
            num_interp_q <= num_interp_d;
        end
    end

    // Next state and datapath controls
    always_comb begin
        state_d      = state_q;
        calc_cnt_d   = calc_cnt_q;
        out_ix_d     = out_ix_q;
        out_iy_d     = out_iy_q;
        blk_idx_d    = blk_idx_q;
        num_interp_d = num_interp_q;
        ready_c      = 1'b0;
        busy_c       = 1'b0;
        done_c       = 1'b0;
        rst_mv_n_c   = 1'b1;
        valid_c      = 1'b0;
        wr_coords_c  = 1'b0;
        wr_cpmvs_c   = 1'b0;
        wr_gen_c     = 1'b0;
        wr_x_c       = 1'b0;
        wr_y_c       = 1'b0;
        wr_cnt_c     = 1'b0;
        sel_x_c      = 1'b0;
        sel_y_c      = 1'b0;

        unique case (state_q)
            S_CLEAR: begin
                rst_mv_n_c = 1'b0;
                state_d    = S_IDLE;
            end

            S_IDLE: begin
                ready_c = 1'b1;
                if (START && !ABORT) begin
                    wr_coords_c  = 1'b1;
                    wr_cpmvs_c   = 1'b1;
                    num_interp_d = '0;
                    blk_idx_d    = '0;
                    state_d      = S_INIT;
                end
            end

            S_INIT: begin
                busy_c     = 1'b1;
                calc_cnt_d = '0;
                if (ABORT) begin
                    state_d = S_CLEAR;
                end else begin
                    wr_x_c  = 1'b1;
                    wr_y_c  = 1'b1;
                    state_d = S_CALC;
                end
            end

            S_CALC: begin
                busy_c = 1'b1;
                if (ABORT) begin
                    calc_cnt_d = '0;
                    state_d    = S_CLEAR;
                end else if (calc_cnt_q == CNT_LAST) begin
                    // Generator output settled: capture MVs and interp flags
                    wr_gen_c     = 1'b1;
                    out_ix_d     = INTERP_X;
                    out_iy_d     = INTERP_Y;
                    num_interp_d = num_interp_q + NUM_W'(INTERP_X | INTERP_Y);
                    calc_cnt_d   = '0;
                    state_d      = S_EMIT;
                end else begin
                    calc_cnt_d = calc_cnt_q + CNT_W'(1);
                end
            end

            S_EMIT: begin
                busy_c = 1'b1;
                if (ABORT) begin
                    state_d = S_CLEAR;
                end else begin
                    valid_c = 1'b1;
                    if (OUT_READY) begin
                        wr_cnt_c  = 1'b1;
                        blk_idx_d = blk_idx_q + IDX_W'(1);
                        // Flags reflect the subblock just emitted
                        unique case ({CTRL_X, CTRL_Y})
                            2'b11, 2'b01: begin
                                wr_x_c  = 1'b1;
                                sel_x_c = 1'b1;
                                state_d = S_CALC;
                            end
                            2'b10: begin
                                wr_x_c  = 1'b1;
                                wr_y_c  = 1'b1;
                                sel_y_c = 1'b1;
                                state_d = S_CALC;
                            end
                            default: state_d = S_DONE;
                        endcase
                    end
                end
            end

            S_DONE: begin
                busy_c     = 1'b1;
                rst_mv_n_c = 1'b0;
                if (ABORT) begin
                    state_d = S_CLEAR;
                end else begin
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_CLEAR;
        endcase
    end

    // Reset overrides every control output in the same cycle
    assign READY                 = ready_c     & ~RST;
    assign BUSY                  = busy_c      & ~RST;
    assign DONE                  = done_c      & ~RST;
    assign RST_ASYNC_MV_GEN      = rst_mv_n_c  & ~RST;
    assign OUT_VALID             = valid_c     & ~RST;
    assign WRITE_REGS_COORDS     = wr_coords_c & ~RST;
    assign WRITE_REGS_CPMVS      = wr_cpmvs_c  & ~RST;
    assign WRITE_REGS_GEN_MVS    = wr_gen_c    & ~RST;
    assign WRITE_REG_X           = wr_x_c      & ~RST;
    assign WRITE_REG_Y           = wr_y_c      & ~RST;
    assign WRITE_REG_COUNT_BLOCK = wr_cnt_c    & ~RST;
    assign SEL_X                 = sel_x_c     & ~RST;
    assign SEL_Y                 = sel_y_c     & ~RST;
    assign OUT_INTERP_X          = out_ix_q;
    assign OUT_INTERP_Y          = out_iy_q;
    assign OUT_BLK_IDX           = blk_idx_q;
    assign NUM_INTERP            = num_interp_q;

endmodule

// File: tb/tb_mv_gen_ctrl.sv
// tb_mv_gen_ctrl: scoreboard bench for mv_gen_ctrl. Instance 0 uses
// CALC_LAT=1, instance 1 uses CALC_LAT=3. A small datapath model counts
// subblocks and drives CTRL_X/CTRL_Y and per-subblock INTERP flags.
module tb_mv_gen_ctrl;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_pass = 0;
    int n_tot  = 0;

    logic start [2], abort [2], out_ready [2];
    logic ready [2], busy [2], done [2];
    logic ctrl_x [2], ctrl_y [2], interp_x [2], interp_y [2];
    logic rst_mv [2], wr_coords [2], wr_cpmvs [2], wr_gen [2];
    logic wr_x [2], wr_y [2], wr_cnt [2], sel_x [2], sel_y [2];
    logic out_valid [2], out_ix [2], out_iy [2];
    logic [3:0]  blk_idx [2];
    logic [4:0]  num_interp [2];
    logic [15:0] ix_tab [2], iy_tab [2];

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [3:0] dp_cnt;

        mv_gen_ctrl #(.CALC_LAT(g == 0 ? 1 : 3)) u_dut (
            .CLK                   (CLK),
            .RST                   (RST),
            .START                 (start[g]),
            .ABORT                 (abort[g]),
            .READY                 (ready[g]),
            .BUSY                  (busy[g]),
            .DONE                  (done[g]),
            .CTRL_X                (ctrl_x[g]),
            .CTRL_Y                (ctrl_y[g]),
            .INTERP_X              (interp_x[g]),
            .INTERP_Y              (interp_y[g]),
            .RST_ASYNC_MV_GEN      (rst_mv[g]),
            .WRITE_REGS_COORDS     (wr_coords[g]),
            .WRITE_REGS_CPMVS      (wr_cpmvs[g]),
            .WRITE_REGS_GEN_MVS    (wr_gen[g]),
            .WRITE_REG_X           (wr_x[g]),
            .WRITE_REG_Y           (wr_y[g]),
            .WRITE_REG_COUNT_BLOCK (wr_cnt[g]),
            .SEL_X                 (sel_x[g]),
            .SEL_Y                 (sel_y[g]),
            .OUT_VALID             (out_valid[g]),
            .OUT_READY             (out_ready[g]),
            .OUT_INTERP_X          (out_ix[g]),
            .OUT_INTERP_Y          (out_iy[g]),
            .OUT_BLK_IDX           (blk_idx[g]),
            .NUM_INTERP            (num_interp[g])
        );

        // Datapath subblock counter model
        always @(posedge CLK) begin
            if (!rst_mv[g])     dp_cnt <= 4'd0;
            else if (wr_cnt[g]) dp_cnt <= dp_cnt + 4'd1;
        end
        assign ctrl_x[g]   = (dp_cnt[3:2] != 2'd3);
        assign ctrl_y[g]   = (dp_cnt[1:0] != 2'd3);
        assign interp_x[g] = ix_tab[g][dp_cnt];
        assign interp_y[g] = iy_tab[g][dp_cnt];
    end

    typedef struct packed {
        logic       is_done;
        logic [4:0] val;      // subblock index, or NUM_INTERP for DONE
        logic       ix;
        logic       iy;
        logic [4:0] ctl;      // {WR_CNT, WR_X, SEL_X, WR_Y, SEL_Y} at handshake
        int         cyc;
        int         gen_cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   gen_cnt [2];

    task automatic check(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int q_size(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t q_front(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    task automatic q_pop(input int i);
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic q_push(input int i, input exp_t e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Monitor: compares every DUT output event against the scoreboard
    task automatic mon(input int i);
        exp_t f;
        if (wr_coords[i]) gen_cnt[i] = 0;
        if (wr_gen[i]) begin
            gen_cnt[i]++;
            if (q_size(i) == 0) check("gen_unexpected", 1, 0);
            else begin
                f = q_front(i);
                check("gen_cycle", cyc, f.gen_cyc);
            end
        end
        if (out_valid[i]) begin
            f = (q_size(i) == 0) ? '0 : q_front(i);
            if (q_size(i) == 0 || f.is_done) check("valid_unexpected", 1, 0);
            else begin
                check("blk_idx", int'(blk_idx[i]), int'(f.val));
                if (out_ready[i]) begin
                    check("hs_cycle", cyc, f.cyc);
                    check("hs_interp", int'({out_ix[i], out_iy[i]}), int'({f.ix, f.iy}));
                    check("hs_ctl", int'({wr_cnt[i], wr_x[i], sel_x[i], wr_y[i], sel_y[i]}),
                          int'(f.ctl));
                    check("hs_gen_cnt", gen_cnt[i], int'(f.val) + 1);
                    q_pop(i);
                end else begin
                    check("stall_enables", int'({wr_coords[i], wr_cpmvs[i], wr_gen[i],
                                                 wr_x[i], wr_y[i], wr_cnt[i]}), 0);
                end
            end
        end
        if (done[i]) begin
            f = (q_size(i) == 0) ? '0 : q_front(i);
            if (q_size(i) == 0 || !f.is_done) check("done_unexpected", 1, 0);
            else begin
                check("done_cycle", cyc, f.cyc);
                check("done_num_interp", int'(num_interp[i]), int'(f.val));
                check("done_gen_cnt", gen_cnt[i], 16);
                q_pop(i);
            end
        end
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < 2; i++) mon(i);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Expected handshakes/DONE for one job accepted at cycle c0
    task automatic push_job(input int i, input int c0, input int lat, input int stall_idx,
                            input int stall_len, input int n_sb, input bit with_done);
        exp_t e;
        int   shift;
        int   em;
        int   nint;
        shift = 0;
        nint  = 0;
        for (int k = 0; k < n_sb; k++) begin
            em        = c0 + 2 + lat + (lat + 1) * k + shift;
            e         = '0;
            e.val     = 5'(k);
            e.ix      = ix_tab[i][k];
            e.iy      = iy_tab[i][k];
            e.ctl     = (k == 15) ? 5'b10000 : ((k % 4) == 3) ? 5'b11011 : 5'b11100;
            e.gen_cyc = em - 1;
            e.cyc     = em + ((k == stall_idx) ? stall_len : 0);
            if (k == stall_idx) shift += stall_len;
            q_push(i, e);
        end
        if (with_done) begin
            for (int k = 0; k < 16; k++) nint += int'(ix_tab[i][k] | iy_tab[i][k]);
            e         = '0;
            e.is_done = 1'b1;
            e.val     = 5'(nint);
            e.cyc     = c0 + 2 + (lat + 1) * 16 + stall_len;
            q_push(i, e);
        end
    endtask

    task automatic run_job(input int i, input int lat, input int stall_idx,
                           input int stall_len, input int abort_idx, input bit noise);
        int c0, done_rel, abort_rel, stall_rel, end_rel, n_sb, nint;
        c0        = cyc;
        done_rel  = 2 + (lat + 1) * 16 + stall_len;
        abort_rel = (abort_idx >= 0) ? 2 + lat + (lat + 1) * abort_idx : -10;
        stall_rel = (stall_idx >= 0) ? 2 + lat + (lat + 1) * stall_idx : -10;
        end_rel   = (abort_idx >= 0) ? abort_rel + 2 : done_rel + 1;
        n_sb      = (abort_idx >= 0) ? abort_idx + 1 : 16;
        nint      = 0;
        for (int k = 0; k < n_sb; k++) nint += int'(ix_tab[i][k] | iy_tab[i][k]);
        push_job(i, c0, lat, stall_idx, stall_len, n_sb, abort_idx < 0);
        for (int r = 0; r <= end_rel; r++) begin
            start[i]     = (r == 0) || (noise && r >= 10 && r <= 20);
            out_ready[i] = !(r >= stall_rel && r < stall_rel + stall_len);
            abort[i]     = (r == abort_rel);
            @(negedge CLK);
            if (r == 0) check("accept_writes", int'({wr_coords[i], wr_cpmvs[i]}), 3);
            if (r == 1) check("init_ctl", int'({wr_x[i], wr_y[i], sel_x[i], sel_y[i]}), 12);
            if (noise && r == 15) check("start_ignored", int'(wr_coords[i]), 0);
            if (r == abort_rel)
                check("abort_outputs", int'({out_valid[i], wr_cnt[i], wr_x[i], wr_gen[i],
                                             done[i]}), 0);
            if (r == abort_rel + 1)
                check("abort_clear", int'({rst_mv[i], ready[i], busy[i]}), 0);
            if (abort_idx >= 0 && r == abort_rel + 2) begin
                check("abort_ready", int'(ready[i]), 1);
                check("abort_num_interp", int'(num_interp[i]), nint);
            end
            if (abort_idx < 0 && r == done_rel + 1) begin
                check("ready_after_done", int'({ready[i], busy[i]}), 2);
                check("num_interp_hold", int'(num_interp[i]), nint);
            end
            tick();
        end
        start[i]     = 1'b0;
        abort[i]     = 1'b0;
        out_ready[i] = 1'b1;
        if (abort_idx >= 0) begin
            check("abort_leftover", q_size(i), 1);
            if (q_size(i) > 0) q_pop(i);
        end else begin
            check("queue_drained", q_size(i), 0);
        end
    endtask

    initial begin
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i]     = 1'b0;
            abort[i]     = 1'b0;
            out_ready[i] = 1'b1;
            ix_tab[i]    = 16'h0;
            iy_tab[i]    = 16'h0;
            gen_cnt[i]   = 0;
        end

        // Reset: clear forced, everything else quiet
        repeat (3) begin
            @(negedge CLK);
            check("rst_mv_in_reset", int'(rst_mv[0]), 0);
            check("rst_outputs", int'({ready[0], busy[0], done[0], out_valid[0], wr_coords[0],
                                       wr_cpmvs[0], wr_gen[0], wr_x[0], wr_y[0], wr_cnt[0]}), 0);
            tick();
        end
        RST = 1'b0;
        @(negedge CLK);
        check("clear_state", int'({rst_mv[0], ready[0], busy[0]}), 0);
        tick();
        @(negedge CLK);
        check("idle_ready", int'({rst_mv[0], ready[0], busy[0]}), 6);
        check("reset_regs", int'({blk_idx[0], num_interp[0], out_ix[0], out_iy[0]}), 0);
        check("idle_ready_lat3", int'(ready[1]), 1);

        // START with ABORT in IDLE is refused
        start[0] = 1'b1;
        abort[0] = 1'b1;
        @(negedge CLK);
        check("idle_abort_no_accept", int'({wr_coords[0], wr_cpmvs[0]}), 0);
        tick();
        start[0] = 1'b0;
        abort[0] = 1'b0;
        @(negedge CLK);
        check("idle_abort_stays", int'({ready[0], busy[0]}), 2);
        tick();

        // Full job, no interp
        run_job(0, 1, -1, 0, -1, 1'b0);

        // Backpressure at subblock 6 plus interp counting
        ix_tab[0] = 16'h0021;
        iy_tab[0] = 16'h0020;
        run_job(0, 1, 6, 5, -1, 1'b0);

        // Abort during EMIT of subblock 9
        ix_tab[0] = 16'h0404;
        iy_tab[0] = 16'h0000;
        run_job(0, 1, -1, 0, 9, 1'b0);

        // Full job after abort
        ix_tab[0] = 16'h0000;
        iy_tab[0] = 16'h8000;
        run_job(0, 1, -1, 0, -1, 1'b0);

        // CALC_LAT=3 with START noise mid-job
        ix_tab[1] = 16'h0102;
        iy_tab[1] = 16'h0000;
        run_job(1, 3, -1, 0, -1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
